// File: rtl/sca_blk_pool.sv
// SCA free-block pool: allocates write blocks on LCT, queues them until the
// L1A decision, hands matched blocks to readout and recycles the rest.
module sca_blk_pool #(
    parameter int unsigned NBLK  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PHW   = 1
) (
    input  logic                       CLK,
    input  logic                       RST_B,
    input  logic                       ALLOC,
    input  logic [PHW-1:0]             PHASE_IN,
    input  logic                       DEC_VLD,
    input  logic                       DEC_MATCH,
    input  logic                       RELEASE,
    input  logic [$clog2(NBLK)-1:0]    REL_ADR,
    input  logic                       ERR_CLR,
    output logic [$clog2(NBLK)-1:0]    WADR,
    output logic                       ALLOC_ACK,
    output logic [$clog2(NBLK)-1:0]    PEND_ADR,
    output logic [PHW-1:0]             PEND_PHASE,
    output logic                       PEND_EMPTY_B,
    output logic                       RD_VLD,
    output logic [$clog2(NBLK)-1:0]    RD_ADR,
    output logic [PHW-1:0]             RD_PHASE,
    output logic [$clog2(NBLK):0]      NFREE,
    output logic [$clog2(DEPTH):0]     NPEND,
    output logic                       SCAFULL,
    output logic                       FIFO_FULL,
    output logic [7:0]                 DROPCNT,
    output logic                       OVF_ERR,
    output logic                       DEC_ERR,
    output logic                       REL_ERR
);

    localparam int unsigned AW = $clog2(NBLK);
    localparam int unsigned DW = $clog2(DEPTH);
    localparam int unsigned EW = AW + PHW;

    // Registered state
    logic [NBLK-1:0]  busy_q, busy_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      nfree_q, nfree_d;
    logic [DW:0]      npend_q, npend_d;
    logic [AW-1:0]    wadr_q;
    logic             ack_q;
    logic             rd_vld_q;
    logic [AW-1:0]    rd_adr_q;
    logic [PHW-1:0]   rd_ph_q;
    logic             scafull_q;
    logic             ffull_q;
    logic [7:0]       drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             dec_err_q, dec_err_d;
    logic             rel_err_q, rel_err_d;

    // Decoded per-cycle events
    logic [AW-1:0]    free_idx;
    logic [EW-1:0]    head;
    logic [AW-1:0]    head_adr;
    logic [PHW-1:0]   head_ph;
    logic             not_empty, fifo_is_full, have_free;
    logic             pop, alloc_ok, drop_ev, ovf_ev, dec_ev;
    logic             nm_free, rd_take, rel_ok, rel_ev;

    // Lowest-index free block from the bitmap as it stands this cycle
    always_comb begin
        free_idx = '0;
        for (int i = int'(NBLK) - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = AW'(i);
        end
    end

    // Event decode: accept/drop, pop, release legality
    always_comb begin
        head         = mem_q[rd_ptr_q];
        head_adr     = head[AW-1:0];
        head_ph      = head[EW-1:AW];
        not_empty    = (npend_q != '0);
        fifo_is_full = (npend_q == (DW+1)'(DEPTH));
        have_free    = (nfree_q != '0);
        pop          = DEC_VLD & not_empty;
        alloc_ok     = ALLOC & have_free & (~fifo_is_full | pop);
        drop_ev      = ALLOC & ~alloc_ok;
        ovf_ev       = drop_ev & have_free;
        dec_ev       = DEC_VLD & ~not_empty;
        nm_free      = pop & ~DEC_MATCH;
        rd_take      = pop & DEC_MATCH;
        // A release colliding with a same-cycle no-match free counts once and flags
        rel_ok       = RELEASE & busy_q[REL_ADR] & ~(nm_free & (REL_ADR == head_adr));
        rel_ev       = RELEASE & ~rel_ok;
    end

    // Next-state for bitmap, counters, error flags and drop counter
    always_comb begin
        busy_d = busy_q;
        if (alloc_ok) busy_d[free_idx] = 1'b1;
        if (nm_free)  busy_d[head_adr] = 1'b0;
        if (rel_ok)   busy_d[REL_ADR]  = 1'b0;

        nfree_d = nfree_q - (AW+1)'(alloc_ok) + (AW+1)'(nm_free) + (AW+1)'(rel_ok);
        npend_d = npend_q + (DW+1)'(alloc_ok) - (DW+1)'(pop);

        drop_d    = ERR_CLR ? 8'd0 : drop_q;
        ovf_d     = ERR_CLR ? 1'b0 : ovf_q;
        dec_err_d = ERR_CLR ? 1'b0 : dec_err_q;
        rel_err_d = ERR_CLR ? 1'b0 : rel_err_q;
        if (drop_ev && drop_d != 8'hFF) drop_d = drop_d + 8'd1;
        if (ovf_ev) ovf_d     = 1'b1;
        if (dec_ev) dec_err_d = 1'b1;
        if (rel_ev) rel_err_d = 1'b1;
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            busy_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            nfree_q   <= (AW+1)'(NBLK);
            npend_q   <= '0;
            wadr_q    <= '0;
            ack_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_adr_q  <= '0;
            rd_ph_q   <= '0;
            scafull_q <= 1'b0;
            ffull_q   <= 1'b0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
            dec_err_q <= 1'b0;
            rel_err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (alloc_ok) begin
                mem_q[wr_ptr_q] <= {PHASE_IN, free_idx};
                wr_ptr_q        <= wr_ptr_q + DW'(1);
                wadr_q          <= free_idx;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + DW'(1);
            if (rd_take) begin
                rd_adr_q <= head_adr;
                rd_ph_q  <= head_ph;
            end
            nfree_q   <= nfree_d;
            npend_q   <= npend_d;
            ack_q     <= alloc_ok;
            rd_vld_q  <= rd_take;
            scafull_q <= (nfree_d == '0);
            ffull_q   <= (npend_d == (DW+1)'(DEPTH));
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            dec_err_q <= dec_err_d;
            rel_err_q <= rel_err_d;
        end
    end

    assign WADR         = wadr_q;
    assign ALLOC_ACK    = ack_q;
    assign PEND_ADR     = head_adr;
    assign PEND_PHASE   = head_ph;
    assign PEND_EMPTY_B = not_empty;
    assign RD_VLD       = rd_vld_q;
    assign RD_ADR       = rd_adr_q;
    assign RD_PHASE     = rd_ph_q;
    assign NFREE        = nfree_q;
    assign NPEND        = npend_q;
    assign SCAFULL      = scafull_q;
    assign FIFO_FULL    = ffull_q;
    assign DROPCNT      = drop_q;
    assign OVF_ERR      = ovf_q;
    assign DEC_ERR      = dec_err_q;
    assign REL_ERR      = rel_err_q;

endmodule
